// File: rtl/wb_stage_if.sv
// wb_stage_if: retiring-instruction handshake between the MEM stage and
// the write-back stage.
//   valid   - MEM presents a retiring instruction
//   ready   - write-back accepts this cycle
//   dst     - destination GPR index
//   we_     - active-low: instruction writes the GPR
//   is_load - result comes from the data bus instead of data
//   data    - ALU or forwarded result
// Modports: master = MEM stage side, slave = write-back side.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] dst;
    logic              we_;
    logic              is_load;
    logic [DATA_W-1:0] data;

    modport master (output valid, dst, we_, is_load, data, input ready);
    modport slave  (input valid, dst, we_, is_load, data, output ready);
endinterface

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Retires instructions from MEM, waits for load
// data when needed, and drives a registered active-low GPR write port.
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   flush           - kills the instruction being accepted and any waiting load
//   mem             - retiring-instruction handshake (wb_stage_if.slave)
//   ld_ack, ld_data - single-cycle load-return pulse and its data
//   gpr_wr_*        - registered GPR write port, enable active low
//   ld_pending(_dst)- outstanding-load flag and its destination, for hazards
//   retire_cnt      - retired-instruction counter (wraps)
//   err_unexp_ack   - sticky: ld_ack seen while no load was outstanding
//
// state   | meaning
// IDLE    | ready for a new instruction (mem.ready = 1)
// WAIT_LD | load accepted, waiting for ld_ack to write it back
// DRAIN   | waiting load was flushed; swallow its ld_ack without writing
module wb_stage #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    wb_stage_if.slave         mem,
    input  logic              ld_ack,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] gpr_wr_addr,
    output logic [DATA_W-1:0] gpr_wr_data,
    output logic              gpr_wr_we_,
    output logic              ld_pending,
    output logic [ADDR_W-1:0] ld_pending_dst,
    output logic [31:0]       retire_cnt,
    output logic              err_unexp_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state;
    logic   ld_we_;
    logic   accept;
    logic   mem_r0_block;

    assign mem.ready  = (state == IDLE);
    assign ld_pending = (state == WAIT_LD);
    assign accept     = mem.valid & mem.ready & ~flush;

    // Writes to index 0 are dropped when r0 is hardwired; the instruction
    // still retires. Folded into the captured we_ for loads.
    assign mem_r0_block = R0_HARDWIRED && (mem.dst == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            gpr_wr_we_     <= 1'b1;
            gpr_wr_addr    <= '0;
            gpr_wr_data    <= '0;
            ld_pending_dst <= '0;
            ld_we_         <= 1'b1;
            retire_cnt     <= '0;
            err_unexp_ack  <= 1'b0;
        end else begin
            // Write enable is a one-cycle pulse per write.
            gpr_wr_we_ <= 1'b1;

            if (ld_ack && (state == IDLE))
                err_unexp_ack <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (mem.is_load) begin
                            ld_pending_dst <= mem.dst;
                            ld_we_         <= mem.we_ | mem_r0_block;
                            state          <= WAIT_LD;
                        end else begin
                            gpr_wr_we_  <= mem.we_ | mem_r0_block;
                            gpr_wr_addr <= mem.dst;
                            gpr_wr_data <= mem.data;
                            retire_cnt  <= retire_cnt + 32'd1;
                        end
                    end
                end
                WAIT_LD: begin
                    if (ld_ack) begin
                        // A flush in the ack cycle kills the load outright.
                        if (!flush) begin
                            gpr_wr_we_  <= ld_we_;
                            gpr_wr_addr <= ld_pending_dst;
                            gpr_wr_data <= ld_data;
                            retire_cnt  <= retire_cnt + 32'd1;
                        end
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ld_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam bit R0H    = 1'b1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              ld_ack = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic [ADDR_W-1:0] gpr_wr_addr;
    logic [DATA_W-1:0] gpr_wr_data;
    logic              gpr_wr_we_;
    logic              ld_pending;
    logic [ADDR_W-1:0] ld_pending_dst;
    logic [31:0]       retire_cnt;
    logic              err_unexp_ack;

    wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_HARDWIRED(R0H)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .mem            (mem_if.slave),
        .ld_ack         (ld_ack),
        .ld_data        (ld_data),
        .gpr_wr_addr    (gpr_wr_addr),
        .gpr_wr_data    (gpr_wr_data),
        .gpr_wr_we_     (gpr_wr_we_),
        .ld_pending     (ld_pending),
        .ld_pending_dst (ld_pending_dst),
        .retire_cnt     (retire_cnt),
        .err_unexp_ack  (err_unexp_ack)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Reference model: a record of the outstanding load plus expected outputs.
    bit          m_wait, m_drain, m_err, m_lwe;
    logic [4:0]  m_ldst;
    logic [31:0] m_cnt;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_drain = 0; m_err = 0; m_lwe = 1; m_ldst = '0;
        m_cnt = '0; m_we = 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".we_"}, {31'd0, gpr_wr_we_}, {31'd0, m_we});
        if (!m_we) begin
            check({tag, ".addr"}, {27'd0, gpr_wr_addr}, {27'd0, m_addr});
            check({tag, ".data"}, gpr_wr_data, m_data);
        end
        check({tag, ".ready"}, {31'd0, mem_if.ready}, {31'd0, !m_wait && !m_drain});
        check({tag, ".pending"}, {31'd0, ld_pending}, {31'd0, m_wait});
        if (m_wait)
            check({tag, ".pend_dst"}, {27'd0, ld_pending_dst}, {27'd0, m_ldst});
        check({tag, ".cnt"}, retire_cnt, m_cnt);
        check({tag, ".err"}, {31'd0, err_unexp_ack}, {31'd0, m_err});
    endtask

    // Drive one cycle of inputs, predict the outcome, clock, compare.
    task automatic step(input string tag, input bit v, input logic [4:0] dst,
                        input bit we_, input bit ld, input logic [31:0] d,
                        input bit fl, input bit ack, input logic [31:0] ldd);
        bit rdy;
        mem_if.valid = v; mem_if.dst = dst; mem_if.we_ = we_;
        mem_if.is_load = ld; mem_if.data = d;
        flush = fl; ld_ack = ack; ld_data = ldd;

        rdy  = !m_wait && !m_drain;
        m_we = 1;
        if (ack && rdy) m_err = 1;
        if (rdy) begin
            if (v && !fl) begin
                if (ld) begin
                    m_wait = 1; m_ldst = dst; m_lwe = we_;
                end else begin
                    m_we = we_ | (R0H && dst == 0);
                    m_addr = dst; m_data = d; m_cnt = m_cnt + 1;
                end
            end
        end else if (m_wait) begin
            if (ack) begin
                m_wait = 0;
                if (!fl) begin
                    m_we = m_lwe | (R0H && m_ldst == 0);
                    m_addr = m_ldst; m_data = ldd; m_cnt = m_cnt + 1;
                end
            end else if (fl) begin
                m_wait = 0; m_drain = 1;
            end
        end else if (ack) begin
            m_drain = 0;
        end

        cyc();
        check_all(tag);
    endtask

    task automatic idle_inputs();
        mem_if.valid = 0; mem_if.dst = '0; mem_if.we_ = 1; mem_if.is_load = 0;
        mem_if.data = '0; flush = 0; ld_ack = 0; ld_data = '0;
    endtask

    // Assert reset between clock edges and check it takes effect at once.
    task automatic mid_reset(input string tag);
        #3;
        idle_inputs();
        rst = 1;
        #1;
        check({tag, ".we_"}, {31'd0, gpr_wr_we_}, 32'd1);
        check({tag, ".ready"}, {31'd0, mem_if.ready}, 32'd1);
        check({tag, ".cnt"}, retire_cnt, 32'd0);
        check({tag, ".pending"}, {31'd0, ld_pending}, 32'd0);
        check({tag, ".err"}, {31'd0, err_unexp_ack}, 32'd0);
        model_reset();
        #1;
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        cyc(); cyc();
        rst = 0;
        check_all("reset");

        // Async reset with a write on the port and a nonzero counter.
        step("alu_pre", 1, 5'd2, 0, 0, 32'h0000_00AA, 0, 0, 0);
        mid_reset("rst_mid_write");

        // Async reset mid-load; its late ack is then unexpected.
        step("ld_pre", 1, 5'd6, 0, 1, 0, 0, 0, 0);
        check("ld_pre.ready0", {31'd0, mem_if.ready}, 32'd0);
        mid_reset("rst_mid_load");
        step("late_ack", 0, 0, 1, 0, 0, 0, 1, 32'h1234_5678);
        check("late_ack.err", {31'd0, err_unexp_ack}, 32'd1);
        mid_reset("rst_clear_err");

        // Back-to-back ALU writes.
        step("b2b_3", 1, 5'd3, 0, 0, 32'h1111_1111, 0, 0, 0);
        check("b2b_3.addr_c", {27'd0, gpr_wr_addr}, 32'd3);
        step("b2b_4", 1, 5'd4, 0, 0, 32'h2222_2222, 0, 0, 0);
        check("b2b_4.data_c", gpr_wr_data, 32'h2222_2222);
        check("b2b.cnt_c", retire_cnt, 32'd2);
        step("b2b_idle", 0, 0, 1, 0, 0, 0, 0, 0);

        // Load to r7 with ack three cycles after acceptance.
        step("ld7_acc", 1, 5'd7, 0, 1, 0, 0, 0, 0);
        step("ld7_w1", 1, 5'd8, 0, 0, 32'h5555_5555, 0, 0, 0);
        check("ld7_w1.pdst_c", {27'd0, ld_pending_dst}, 32'd7);
        step("ld7_w2", 0, 0, 1, 0, 0, 0, 0, 0);
        step("ld7_ack", 0, 0, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("ld7.data_c", gpr_wr_data, 32'hDEAD_BEEF);
        check("ld7.ready_c", {31'd0, mem_if.ready}, 32'd1);
        check("ld7.cnt_c", retire_cnt, 32'd3);

        // Flush one cycle after a load; ack arrives in DRAIN.
        step("ld9_acc", 1, 5'd9, 0, 1, 0, 0, 0, 0);
        step("ld9_flush", 0, 0, 1, 0, 0, 1, 0, 0);
        step("ld9_drain", 1, 5'd10, 0, 0, 32'h7777_7777, 0, 0, 0);
        step("ld9_ack", 0, 0, 1, 0, 0, 0, 1, 32'hBAD0_BAD0);
        check("ld9.cnt_c", retire_cnt, 32'd3);
        check("ld9.we_c", {31'd0, gpr_wr_we_}, 32'd1);

        // Flush and ack in the same cycle.
        step("ldA_acc", 1, 5'd11, 0, 1, 0, 0, 0, 0);
        step("ldA_flack", 0, 0, 1, 0, 0, 1, 1, 32'hCAFE_F00D);

        // Flushed accept is killed.
        step("alu_flushed", 1, 5'd12, 0, 0, 32'h9999_9999, 1, 0, 0);

        // r0 writes suppressed but still retire; also a load to r0.
        step("r0_alu", 1, 5'd0, 0, 0, 32'hFFFF_0000, 0, 0, 0);
        check("r0.we_c", {31'd0, gpr_wr_we_}, 32'd1);
        check("r0.cnt_c", retire_cnt, 32'd4);
        step("r0_ld", 1, 5'd0, 0, 1, 0, 0, 0, 0);
        step("r0_ldack", 0, 0, 1, 0, 0, 0, 1, 32'h0BAD_0BAD);

        // ALU op that does not write the GPR still retires.
        step("nowr", 1, 5'd13, 1, 0, 32'h1, 0, 0, 0);

        // Counter wrap.
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        check("wrap.preload", retire_cnt, 32'hFFFF_FFFF);
        step("wrap_alu", 1, 5'd14, 0, 0, 32'h4242_4242, 0, 0, 0);
        check("wrap.cnt_c", retire_cnt, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 $urandom(),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0),
                 $urandom());
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
